// File: rtl/mod_reduction_arbiter_if.sv
// Channels around mod_reduction_arbiter: per-requester requests, the shared response and the ModReduction link.
// slave is the arbiter's view; master is the view of the surrounding datapath (requesters, consumer, reducer).
interface mod_reduction_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int width = 128,
    parameter int IDW   = 3
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*2*width-1:0] req_a;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [width-1:0]        rsp_r;
    logic                    rsp_ready;
    logic                    mr_enable;
    logic [2*width-1:0]      mr_a;
    logic                    mr_done;
    logic [width-1:0]        mr_r;

    modport slave (
        input  req_valid, req_a, rsp_ready, mr_done, mr_r,
        output req_ready, rsp_valid, rsp_id, rsp_r, mr_enable, mr_a
    );

    modport master (
        output req_valid, req_a, rsp_ready, mr_done, mr_r,
        input  req_ready, rsp_valid, rsp_id, rsp_r, mr_enable, mr_a
    );
endinterface

// File: rtl/mod_reduction_arbiter.sv
// Round-robin sharing of one multi-cycle ModReduction among NREQ requesters; results return on a
// single response channel tagged with the owning requester index.
module mod_reduction_arbiter #(
    parameter int NREQ  = 4,
    parameter int width = 128,
    parameter int IDW   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    mod_reduction_arbiter_if.slave bus,
    output logic                   busy,
    output logic [31:0]            op_count
);
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state, state_nx;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     win_idx;
    logic               win_found;
    logic [2*width-1:0] win_a;
    logic [SW-1:0]      scan;
    logic               accept;
    logic               finish;
    logic               handoff;

    // Winner is the first valid requester scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin : arbitrate
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        win_a     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NREQ)) begin
                scan = scan - SW'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && bus.req_valid[j] && (scan == SW'(j))) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(j);
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (win_idx == IDW'(j)) begin
                win_a = bus.req_a[j*2*width +: 2*width];
            end
        end
    end

    assign accept  = (state == IDLE) && win_found;
    assign finish  = (state == BUSY) && bus.mr_done;
    assign handoff = (state == RESP) && bus.rsp_valid && bus.rsp_ready;
    assign busy    = (state != IDLE);

    always_comb begin : grant
        bus.req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            bus.req_ready[j] = accept && (win_idx == IDW'(j));
        end
    end

    always_comb begin : fsm_next
        state_nx = state;
        case (state)
            IDLE:    if (accept)  state_nx = BUSY;
            BUSY:    if (finish)  state_nx = RESP;
            RESP:    if (handoff) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // mr_enable stays high across BUSY and is dropped on the done edge, so RESP always gives the
    // reducer at least one enable-low cycle before the next operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            id_q          <= '0;
            bus.mr_enable <= 1'b0;
            bus.mr_a      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_r     <= '0;
            op_count      <= '0;
        end else begin
            if (accept) begin
                bus.mr_a      <= win_a;
                id_q          <= win_idx;
                bus.mr_enable <= 1'b1;
                rr_ptr        <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
            end
            if (finish) begin
                bus.rsp_r     <= bus.mr_r;
                bus.rsp_id    <= id_q;
                bus.rsp_valid <= 1'b1;
                bus.mr_enable <= 1'b0;
            end
            if (handoff) begin
                bus.rsp_valid <= 1'b0;
                op_count      <= op_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_mod_reduction_arbiter.sv
// Bench for mod_reduction_arbiter: behavioural ModReduction (p=37) plus a queue-based reference model,
// directed scenarios followed by randomized request/backpressure traffic.
module tb_mod_reduction_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 128;
    localparam int AW   = 2 * W;
    localparam int IDW  = 3;
    localparam int P    = 37;
    localparam int L    = 3;

    typedef struct {
        int     id;
        longint a;
        longint r;
    } op_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [31:0] op_count;
    logic        force_done = 1'b0;
    logic        model_done;
    logic [W-1:0] model_r;
    int          model_cnt;

    longint      a_val [NREQ];
    op_t         exp_q[$];
    op_t         resp_log[$];
    int          grant_log[$];

    int          m_rr     = 0;
    bit          m_idle   = 1'b1;
    int unsigned m_ops    = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    bit          rsp_seen = 1'b0;
    bit          prev_valid = 1'b0;
    logic [IDW-1:0] prev_id = '0;
    logic [W-1:0]   prev_r  = '0;

    int          errors = 0;
    int          checks = 0;

    mod_reduction_arbiter_if #(.NREQ(NREQ), .width(W), .IDW(IDW)) bus ();

    mod_reduction_arbiter #(.NREQ(NREQ), .width(W), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    function automatic longint mod_p(input longint a);
        longint r;
        r = a % P;
        if (r < 0) r = r + P;
        return r;
    endfunction

    function automatic logic [AW-1:0] sext(input longint a);
        return AW'(a);
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in ModReduction: done L edges after enable rises, held until enable drops.
    assign bus.mr_done = model_done | force_done;
    assign bus.mr_r    = model_r;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_done <= 1'b0;
            model_cnt  <= 0;
            model_r    <= '0;
        end else if (!bus.mr_enable) begin
            model_done <= 1'b0;
            model_cnt  <= 0;
        end else if (!model_done) begin
            if (model_cnt == L - 1) begin
                model_done <= 1'b1;
                model_r    <= W'(mod_p($signed(bus.mr_a[63:0])));
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end
    end

    // Reference model: sampled on the falling edge, predicts the next rising edge.
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] exp_rdy;
        int  w;
        int  idx;
        bit  found;
        op_t e;
        cyc++;
        if (!reset) begin
            exp_q.delete();
            m_rr       = 0;
            m_idle     = 1'b1;
            m_ops      = 0;
            prev_valid = 1'b0;
            rsp_seen   = 1'b0;
        end else begin
            check("busy", 256'(busy), 256'(!m_idle));
            check("op_count", 256'(op_count), 256'(m_ops));
            if (m_idle) begin
                check("idle_rsp_valid", 256'(bus.rsp_valid), 256'(0));
                check("idle_mr_enable", 256'(bus.mr_enable), 256'(0));
            end
            if (bus.rsp_valid) check("resp_mr_enable", 256'(bus.mr_enable), 256'(0));
            if (bus.mr_enable && exp_q.size() > 0) check("mr_a", 256'(bus.mr_a), 256'(sext(exp_q[0].a)));
            if (prev_valid) begin
                check("hold_valid", 256'(bus.rsp_valid), 256'(1));
                check("hold_id", 256'(bus.rsp_id), 256'(prev_id));
                check("hold_r", 256'(bus.rsp_r), 256'(prev_r));
            end
            // Accept edge to rsp_valid is L+1 edges, which is L+2 falling-edge samples from the accept sample.
            if (bus.rsp_valid && !rsp_seen && !m_idle) begin
                rsp_seen = 1'b1;
                check("latency", 256'(cyc - acc_cyc), 256'(L + 2));
            end

            exp_rdy = '0;
            found   = 1'b0;
            w       = 0;
            if (m_idle) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_rr + k) % NREQ;
                    if (!found && bus.req_valid[idx]) begin
                        found = 1'b1;
                        w     = idx;
                    end
                end
            end
            if (found) exp_rdy[w] = 1'b1;
            check("req_ready", 256'(bus.req_ready), 256'(exp_rdy));
            if (found) begin
                e.id = w;
                e.a  = a_val[w];
                e.r  = mod_p(a_val[w]);
                exp_q.push_back(e);
                grant_log.push_back(w);
                m_rr     = (w + 1) % NREQ;
                m_idle   = 1'b0;
                acc_cyc  = cyc;
                rsp_seen = 1'b0;
            end

            prev_valid = bus.rsp_valid && !bus.rsp_ready;
            prev_id    = bus.rsp_id;
            prev_r     = bus.rsp_r;
            if (bus.rsp_valid && bus.rsp_ready) begin
                e.id = int'(bus.rsp_id);
                e.a  = 0;
                e.r  = longint'(bus.rsp_r[63:0]);
                resp_log.push_back(e);
                if (exp_q.size() == 0) begin
                    check("rsp_without_op", 256'(bus.rsp_valid), 256'(0));
                end else begin
                    check("rsp_id", 256'(bus.rsp_id), 256'(exp_q[0].id));
                    check("rsp_r", 256'(bus.rsp_r), 256'(exp_q[0].r));
                    exp_q.pop_front();
                    m_ops++;
                    m_idle = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input longint a);
        a_val[i]                = a;
        bus.req_a[i*AW +: AW]   = sext(a);
        bus.req_valid[i]        = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic wait_grants(input int n);
        int budget;
        budget = 200;
        while (grant_log.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        if (grant_log.size() < n) check("grant_timeout", 256'(grant_log.size()), 256'(n));
    endtask

    task automatic wait_resps(input int n);
        int budget;
        budget = 200;
        while (resp_log.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        if (resp_log.size() < n) check("resp_timeout", 256'(resp_log.size()), 256'(n));
    endtask

    function automatic longint rand_a();
        case ($urandom % 3)
            0:       return longint'($urandom_range(0, 2000)) - 1000;
            1:       return longint'(int'($urandom));
            default: return longint'({$urandom, $urandom});
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int gb;
        int rb;
        longint ra;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) a_val[i] = 0;

        #1 reset = 1'b0;
        #1;
        check("rst_mr_enable", 256'(bus.mr_enable), 256'(0));
        check("rst_mr_a", 256'(bus.mr_a), 256'(0));
        check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check("rst_rsp_id", 256'(bus.rsp_id), 256'(0));
        check("rst_rsp_r", 256'(bus.rsp_r), 256'(0));
        check("rst_op_count", 256'(op_count), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Single request
        set_req(0, -358);
        wait_grants(1);
        bus.req_valid[0] = 1'b0;
        wait_resps(1);
        tick();
        check("t1_id", 256'(resp_log[0].id), 256'(0));
        check("t1_r", 256'(resp_log[0].r), 256'(12));
        check("t1_op_count", 256'(op_count), 256'(1));
        check("t1_busy", 256'(busy), 256'(0));

        // All four together: round robin from pointer 0
        do_reset();
        gb = grant_log.size();
        rb = resp_log.size();
        set_req(0, 100);
        set_req(1, -1);
        set_req(2, 74);
        set_req(3, 38);
        for (int n = 1; n <= 4; n++) begin
            wait_grants(gb + n);
            bus.req_valid[grant_log[grant_log.size() - 1]] = 1'b0;
        end
        wait_resps(rb + 4);
        check("t2_id0", 256'(resp_log[rb + 0].id), 256'(0));
        check("t2_id1", 256'(resp_log[rb + 1].id), 256'(1));
        check("t2_id2", 256'(resp_log[rb + 2].id), 256'(2));
        check("t2_id3", 256'(resp_log[rb + 3].id), 256'(3));
        check("t2_r0", 256'(resp_log[rb + 0].r), 256'(26));
        check("t2_r1", 256'(resp_log[rb + 1].r), 256'(36));
        check("t2_r2", 256'(resp_log[rb + 2].r), 256'(0));
        check("t2_r3", 256'(resp_log[rb + 3].r), 256'(1));

        // Backpressure while another requester waits
        tick();
        rb = resp_log.size();
        bus.rsp_ready = 1'b0;
        set_req(2, 500);
        gb = grant_log.size();
        wait_grants(gb + 1);
        bus.req_valid[2] = 1'b0;
        set_req(1, -77);
        for (int b = 0; b < 20 && !bus.rsp_valid; b++) tick();
        check("t3_rsp_valid", 256'(bus.rsp_valid), 256'(1));
        for (int h = 0; h < 5; h++) begin
            tick();
            check("t3_hold_valid", 256'(bus.rsp_valid), 256'(1));
            check("t3_hold_id", 256'(bus.rsp_id), 256'(2));
            check("t3_hold_r", 256'(bus.rsp_r), 256'(19));
            check("t3_mr_enable", 256'(bus.mr_enable), 256'(0));
            check("t3_req_ready", 256'(bus.req_ready), 256'(0));
            check("t3_no_accept", 256'(grant_log.size()), 256'(gb + 1));
        end
        bus.rsp_ready = 1'b1;
        wait_grants(gb + 2);
        bus.req_valid[1] = 1'b0;
        wait_resps(rb + 2);
        check("t3_second_id", 256'(resp_log[rb + 1].id), 256'(1));
        check("t3_second_r", 256'(resp_log[rb + 1].r), 256'(34));

        // Fairness between requesters 1 and 3
        tick();
        do_reset();
        gb = grant_log.size();
        rb = resp_log.size();
        set_req(1, 5);
        set_req(3, 9);
        wait_grants(gb + 6);
        bus.req_valid = '0;
        wait_resps(rb + 6);
        for (int k = 0; k < 6; k++) begin
            check("t4_grant", 256'(grant_log[gb + k]), 256'((k % 2 == 0) ? 1 : 3));
        end

        // Reset in the middle of BUSY abandons the operation
        tick();
        gb = grant_log.size();
        set_req(2, 1000);
        wait_grants(gb + 1);
        bus.req_valid[2] = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("t5_mr_enable", 256'(bus.mr_enable), 256'(0));
        check("t5_mr_a", 256'(bus.mr_a), 256'(0));
        check("t5_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check("t5_rsp_id", 256'(bus.rsp_id), 256'(0));
        check("t5_rsp_r", 256'(bus.rsp_r), 256'(0));
        check("t5_op_count", 256'(op_count), 256'(0));
        check("t5_busy", 256'(busy), 256'(0));
        check("t5_req_ready", 256'(bus.req_ready), 256'(0));
        repeat (3) tick();
        reset = 1'b1;
        rb = resp_log.size();
        repeat (10) tick();
        check("t5_no_rsp", 256'(resp_log.size()), 256'(rb));
        set_req(0, -358);
        wait_grants(gb + 2);
        bus.req_valid[0] = 1'b0;
        wait_resps(rb + 1);
        tick();
        check("t5_id", 256'(resp_log[rb].id), 256'(0));
        check("t5_r", 256'(resp_log[rb].r), 256'(12));
        check("t5_count", 256'(op_count), 256'(1));

        // Spurious mr_done while idle
        force_done = 1'b1;
        repeat (4) tick();
        check("t6_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check("t6_op_count", 256'(op_count), 256'(1));
        force_done = 1'b0;
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 1200; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i]) begin
                    if ($urandom % 6 == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    ra = rand_a();
                    set_req(i, ra);
                end
            end
            bus.rsp_ready = ($urandom % 4 != 0);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int b = 0; b < 50 && exp_q.size() > 0; b++) tick();
        check("drain", 256'(exp_q.size()), 256'(0));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_reduction_arbiter.md
# mod_reduction_arbiter

Shares a single multi-cycle `ModReduction` instance among `NREQ` requesters (field multipliers / point-adder lanes in the MSM datapath). Per-requester valid/ready request channels feed a round-robin grant. The arbiter sequences the reducer's `enable`/`done` handshake and returns each reduced result on one shared response channel, tagged with the requester index.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; range 2..8.
- `width`, 128, residue width; operands are `2*width` bits, signed.
- `IDW`, 3, width of `rsp_id`; must satisfy `2**IDW >= NREQ`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_a`  in  NREQ*2*width  operands, packed; requester i occupies bits `[i*2*width +: 2*width]`, signed.
- `req_ready`  out  NREQ  grant/accept, one bit per requester.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_r`  out  width  reduced result in `[0, p)`.
- `rsp_ready`  in  1  consumer accepts the result.
- `mr_enable`  out  1  drives `ModReduction.enable`.
- `mr_a`  out  2*width  drives `ModReduction.a`.
- `mr_done`  in  1  from `ModReduction.done`.
- `mr_r`  in  width  from `ModReduction.r`.
- `busy`  out  1  high whenever the state is not IDLE.
- `op_count`  out  32  number of completed responses; wraps modulo 2^32.

## Operation
FSM states: IDLE, BUSY, RESP.

IDLE
- The winner is the first i with `req_valid[i]` high, scanning from `rr_ptr` upward modulo NREQ.
- `req_ready` is combinational and one-hot on the winner. It is zero if no request is valid.
- On the accept edge (`req_valid[i] & req_ready[i]`):
  - `mr_a <= req_a[i]`, `id_q <= i`, `mr_enable <= 1`.
  - `rr_ptr <= (i+1) mod NREQ`.
  - Go to BUSY.

BUSY
- `mr_enable` and `mr_a` are held constant. `req_ready` is all zero.
- On the edge where `mr_done` is 1:
  - `rsp_r <= mr_r`, `rsp_id <= id_q`, `rsp_valid <= 1`, `mr_enable <= 0`.
  - Go to RESP.

RESP
- `rsp_valid`, `rsp_id` and `rsp_r` are held stable until `rsp_ready` is seen.
- On the edge where `rsp_valid & rsp_ready`:
  - `rsp_valid <= 0`, `op_count <= op_count + 1`.
  - Go to IDLE.
- `mr_enable` is low throughout RESP, which guarantees the reducer at least one enable-low cycle between operations. The reducer requires this to restart.

Rules
- `mr_done` seen in IDLE or RESP is ignored.
- A requester that drops `req_valid` before acceptance loses nothing; arbitration simply re-evaluates.
- `rr_ptr` advances only on an accept.
- Operand arithmetic is pass-through. The arbiter never modifies sign or width of `req_a` or `mr_r`.

Reset (`reset` low, asynchronous, any time)
- State goes to IDLE and `rr_ptr` goes to 0.
- `mr_enable`, `mr_a`, `rsp_valid`, `rsp_id`, `rsp_r`, `op_count` and `busy` are all 0.
- Any in-flight operation is abandoned with no response. Requesters must re-present.

## Timing
- Accept to `mr_enable` high: 1 edge (registered).
- `mr_done` high to `rsp_valid` high: 1 edge.
- Latency from the accept edge to `rsp_valid` is L+1 cycles, where L is the reducer's enable-to-done latency.
- Minimum issue interval is L+3 cycles: accept, L in BUSY, 1 in RESP (when `rsp_ready` is already high), 1 in IDLE.
- `req_ready` may only be high in IDLE. `rsp_valid` may only be high in RESP.
- Fairness: with all requesters continuously valid, grants follow 0,1,2,3,0,… (NREQ=4). No requester waits more than NREQ-1 grants.
- Reset deassertion is synchronised externally. The first accept is possible on the first edge after release.

## Test plan
Bench instantiates `ModReduction` with p=37, width=128.
1. Single request: `req_valid=4'b0001`, `req_a[0]=-10*37+12` (−358) -> one `rsp_valid` with `rsp_id=0`, `rsp_r=12`; `op_count=1`; `busy` low afterwards.
2. All four valid together with a = 100, −1, 74, 38 -> responses in order id 0,1,2,3 with r = 26, 36, 0, 1; at most one `req_ready` bit high in any cycle.
3. Backpressure: `rsp_ready` held low 5 cycles in RESP -> `rsp_valid`, `rsp_id` and `rsp_r` stable; `mr_enable` low; no new accept until the handshake completes.
4. Fairness: requesters 1 and 3 continuously valid for 6 operations -> grant order 1,3,1,3,1,3.
5. Reset mid-BUSY: assert `reset` low two cycles after accept -> all outputs 0 immediately (asynchronous); no response ever issued for that operation; after release a new request with a=−358 returns 12.
6. Spurious `mr_done` forced high in IDLE -> no `rsp_valid`; `op_count` unchanged.
